// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the iterative multiplier sequencer: ALU code and FSM state encoding.
package mul_seq_ctrl_pkg;

  localparam logic [2:0] ALU_MUL = 3'b101;

  typedef enum logic [1:0] {
    MSC_IDLE = 2'b00,
    MSC_RUN  = 2'b01,
    MSC_DONE = 2'b10
  } msc_state_t;

endpackage

// File: rtl/mul_seq_ctrl_mul_step.sv
// One shift-add step: folds BITS_PER_CYCLE multiplier bits into the accumulator.
module mul_step #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [WIDTH-1:0]          acc,
  input  logic [WIDTH-1:0]          mcand,
  input  logic [BITS_PER_CYCLE-1:0] mplier,
  output logic [WIDTH-1:0]          acc_next
);

  always_comb begin
    acc_next = acc;
    for (int unsigned k = 0; k < BITS_PER_CYCLE; k++) begin
      if (mplier[k]) acc_next = acc_next + (mcand << k);
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencer for the multi-cycle EX-stage multiplier: accepts an operand pair, runs
// WIDTH/BITS_PER_CYCLE shift-add cycles, then presents the low WIDTH product bits for one cycle.
module mul_seq_ctrl
  import mul_seq_ctrl_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int RD_W           = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  input  logic [RD_W-1:0]  rd_addr_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [RD_W-1:0]  rd_addr_o
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;

  msc_state_t       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [RD_W-1:0]  rd_q;
  logic [WIDTH-1:0] acc_next;
  logic             accept;

  mul_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .mplier   (mplier[BITS_PER_CYCLE-1:0]),
    .acc_next (acc_next)
  );

  // DONE accepts like IDLE so back-to-back ops see no bubble.
  assign accept  = start_i & ~flush_i & (state != MSC_RUN);
  assign stall_o = accept | (state == MSC_RUN);
  assign busy_o  = (state == MSC_RUN);
  // A flush landing in DONE suppresses the completion pulse that cycle.
  assign done_o  = (state == MSC_DONE) & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= MSC_IDLE;
      count     <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      rd_q      <= '0;
      result_o  <= '0;
      rd_addr_o <= '0;
    end else if (flush_i) begin
      state <= MSC_IDLE;
      count <= '0;
      acc   <= '0;
    end else begin
      case (state)
        MSC_IDLE, MSC_DONE: begin
          if (accept) begin
            mcand  <= rs1_i;
            mplier <= rs2_i;
            rd_q   <= rd_addr_i;
            acc    <= '0;
            count  <= '0;
            state  <= MSC_RUN;
          end else begin
            state <= MSC_IDLE;
          end
        end
        MSC_RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << BITS_PER_CYCLE;
          mplier <= mplier >> BITS_PER_CYCLE;
          count  <= count + 1'b1;
          if (count == CW'(N - 1)) begin
            state     <= MSC_DONE;
            result_o  <= acc_next;
            rd_addr_o <= rd_q;
          end
        end
        default: state <= MSC_IDLE;
      endcase
    end
  end

endmodule
